// File: rtl/ifetch_stage.sv
// Instruction fetch stage with IF/ID register and handshaked imem port.
// Define IFETCH_ALIGN_CHECK_EN to force-align jr targets and flag misalignment.
module ifetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned AW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [1:0]    pcsource,
  input  logic [AW-1:0] jr_target,
  input  logic          stall,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_ready,
  input  logic [31:0]   imem_rdata,
  output logic          id_valid,
  output logic [31:0]   id_instr,
  output logic [AW-1:0] id_pc4,
  output logic [5:0]    op,
  output logic [5:0]    func,
  output logic          misalign_err
);

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    DISCARD = 2'd1,
    HOLD    = 2'd2
  } state_t;

  localparam logic [AW-1:0] RST_PC = RESET_PC[AW-1:0];
  localparam logic [AW-1:0] FOUR = AW'(4);

  state_t        state, state_n;
  logic [AW-1:0] pc, pc_n;
  logic [AW-1:0] fa, fa_n;
  logic          vld_n;
  logic [31:0]   ins_n;
  logic [AW-1:0] pc4_n;
  logic [31:0]   buf_ins, buf_ins_n;
  logic [AW-1:0] buf_pc4, buf_pc4_n;
  logic          redirect;
  logic [AW-1:0] tgt;
  logic          mis;

`ifdef IFETCH_ALIGN_CHECK_EN
  assign tgt = {jr_target[AW-1:2], 2'b00};
  assign mis = (jr_target[1:0] != 2'b00);
`else
  assign tgt = jr_target;
  assign mis = 1'b0;
`endif

  assign redirect  = id_valid && (pcsource == 2'b01) && !stall;
  assign imem_req  = rst_n && (state != HOLD);
  assign imem_addr = fa;
  assign op        = id_instr[31:26];
  assign func      = id_instr[5:0];

  always_comb begin
    state_n   = state;
    pc_n      = pc;
    fa_n      = fa;
    vld_n     = id_valid;
    ins_n     = id_instr;
    pc4_n     = id_pc4;
    buf_ins_n = buf_ins;
    buf_pc4_n = buf_pc4;
    unique case (state)
      FETCH: begin
        if (imem_ready) begin
          if (redirect) begin
            vld_n = 1'b0;
            ins_n = 32'h0;
            fa_n  = tgt;
          end else if (stall) begin
            buf_ins_n = imem_rdata;
            buf_pc4_n = fa + FOUR;
            state_n   = HOLD;
          end else begin
            vld_n = 1'b1;
            ins_n = imem_rdata;
            pc4_n = fa + FOUR;
            fa_n  = fa + FOUR;
          end
        end else if (redirect) begin
          // Request already on the bus must finish before retargeting
          vld_n   = 1'b0;
          ins_n   = 32'h0;
          pc_n    = tgt;
          state_n = DISCARD;
        end else if (!stall) begin
          vld_n = 1'b0;
          ins_n = 32'h0;
        end
      end
      DISCARD: begin
        if (imem_ready) begin
          fa_n    = pc;
          state_n = FETCH;
        end
      end
      HOLD: begin
        if (!stall) begin
          state_n = FETCH;
          if (redirect) begin
            vld_n = 1'b0;
            ins_n = 32'h0;
            fa_n  = tgt;
          end else begin
            vld_n = 1'b1;
            ins_n = buf_ins;
            pc4_n = buf_pc4;
            fa_n  = fa + FOUR;
          end
        end
      end
      default: state_n = FETCH;
    endcase
    if (state_n != DISCARD) pc_n = fa_n;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= FETCH;
      pc       <= RST_PC;
      fa       <= RST_PC;
      id_valid <= 1'b0;
      id_instr <= 32'h0;
      id_pc4   <= '0;
      buf_ins  <= 32'h0;
      buf_pc4  <= '0;
    end else begin
      state    <= state_n;
      pc       <= pc_n;
      fa       <= fa_n;
      id_valid <= vld_n;
      id_instr <= ins_n;
      id_pc4   <= pc4_n;
      buf_ins  <= buf_ins_n;
      buf_pc4  <= buf_pc4_n;
    end
  end

`ifdef IFETCH_ALIGN_CHECK_EN
  logic err_q;
  always_ff @(posedge clk) begin
    if (!rst_n) err_q <= 1'b0;
    else if (redirect && mis) err_q <= 1'b1;
  end
  assign misalign_err = err_q;
`else
  assign misalign_err = 1'b0;
`endif

endmodule

// File: tb/tb_ifetch_stage.sv
// Directed self-checking bench for ifetch_stage.
module tb_ifetch_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  pcsource;
  logic [31:0] jr_target;
  logic        stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc4;
  logic [5:0]  op;
  logic [5:0]  func;
  logic        misalign_err;
  logic        rdy;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [31:0] a);
    return 32'h8C00_0000 ^ a;
  endfunction

  assign imem_ready = rdy && imem_req;
  assign imem_rdata = word(imem_addr);

  ifetch_stage dut (
    .clk(clk), .rst_n(rst_n), .pcsource(pcsource),
    .jr_target(jr_target), .stall(stall),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .id_valid(id_valid), .id_instr(id_instr), .id_pc4(id_pc4),
    .op(op), .func(func), .misalign_err(misalign_err)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic exp_err;

  initial begin
`ifdef IFETCH_ALIGN_CHECK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    rst_n = 1'b0; pcsource = 2'b00; jr_target = '0;
    stall = 1'b0; rdy = 1'b1;
    tick(); tick();
    check("rst_vld", 32'(id_valid), 0);
    check("rst_ins", id_instr, 0);
    check("rst_pc4", id_pc4, 0);
    check("rst_req", 32'(imem_req), 0);
    check("rst_err", 32'(misalign_err), 0);
    rst_n = 1'b1;
    #1;
    check("req_on", 32'(imem_req), 1);
    check("addr0", imem_addr, 0);

    // zero-wait streaming
    tick();
    check("s0_vld", 32'(id_valid), 1);
    check("s0_ins", id_instr, word(0));
    check("s0_pc4", id_pc4, 4);
    check("s0_addr", imem_addr, 4);
    check("s0_op", 32'(op), 32'h23);
    tick();
    check("s1_ins", id_instr, word(4));
    check("s1_addr", imem_addr, 8);

    // 3-cycle wait at 0x8
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("w_vld", 32'(id_valid), 0);
      check("w_addr", imem_addr, 8);
      check("w_func", 32'(func), 0);
    end
    rdy = 1'b1;
    tick();
    check("w_ins", id_instr, word(8));
    check("w_pc4", id_pc4, 32'hC);
    tick();
    check("c_addr", imem_addr, 32'h10);

    // stall while fetch of 0x10 completes
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("h_req", 32'(imem_req), 0);
      check("h_ins", id_instr, word(32'hC));
    end
    stall = 1'b0;
    tick();
    check("h_rel_ins", id_instr, word(32'h10));
    check("h_rel_pc4", id_pc4, 32'h14);
    check("h_rel_addr", imem_addr, 32'h14);
    check("h_rel_req", 32'(imem_req), 1);

    // jr with memory ready the same cycle
    pcsource = 2'b01; jr_target = 32'h100;
    tick();
    pcsource = 2'b00;
    check("j0_vld", 32'(id_valid), 0);
    check("j0_ins", id_instr, 0);
    check("j0_addr", imem_addr, 32'h100);
    tick();
    check("j0_tgt", id_instr, word(32'h100));
    check("j0_pc4", id_pc4, 32'h104);

    // jr while fetch of 0x104 waits two cycles
    rdy = 1'b0; pcsource = 2'b01; jr_target = 32'h200;
    tick();
    pcsource = 2'b00;
    check("j1_vld", 32'(id_valid), 0);
    check("j1_addr", imem_addr, 32'h104);
    tick();
    check("j1_hold", imem_addr, 32'h104);
    rdy = 1'b1;
    tick();
    check("j1_drop", 32'(id_valid), 0);
    check("j1_addr2", imem_addr, 32'h200);
    tick();
    check("j1_ins", id_instr, word(32'h200));

    // wrap-around at the top of the address space
    pcsource = 2'b01; jr_target = 32'hFFFF_FFFC;
    tick();
    pcsource = 2'b00;
    check("wr_addr", imem_addr, 32'hFFFF_FFFC);
    tick();
    check("wr_ins", id_instr, word(32'hFFFF_FFFC));
    check("wr_pc4", id_pc4, 0);
    check("wr_addr2", imem_addr, 0);

    // redirect on leaving HOLD drops the buffer
    stall = 1'b1;
    tick();
    check("hr_req", 32'(imem_req), 0);
    stall = 1'b0; pcsource = 2'b01; jr_target = 32'h40;
    tick();
    pcsource = 2'b00;
    check("hr_vld", 32'(id_valid), 0);
    check("hr_addr", imem_addr, 32'h40);
    tick();
    check("hr_ins", id_instr, word(32'h40));

    // misaligned jr, then reset mid-wait
    rdy = 1'b0; pcsource = 2'b01; jr_target = 32'h102;
    tick();
    pcsource = 2'b00;
    check("ma_err", 32'(misalign_err), 32'(exp_err));
    check("ma_addr", imem_addr, 32'h44);
    rst_n = 1'b0; rdy = 1'b1;
    #1;
    check("ma_req_rst", 32'(imem_req), 0);
    tick();
    check("ma_err_rst", 32'(misalign_err), 0);
    check("ma_vld_rst", 32'(id_valid), 0);
    rst_n = 1'b1;
    #1;
    check("ma_addr_rst", imem_addr, 0);
    tick();
    check("ma_ins_post", id_instr, word(0));
    check("ma_addr_post", imem_addr, 4);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
